// File: rtl/rdid_reader_pkg.sv
// rtl/rdid_reader_pkg.sv - shared constants and state type for the JEDEC ID reader
package rdid_pkg;

    localparam logic [7:0] RDID_CMD        = 8'h9F;
    localparam int         RDID_CMD_BITS   = 8;
    localparam int         RDID_TOTAL_BITS = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        CS_HOLD  = 3'd3,
        DONE     = 3'd4
    } rdid_state_t;

    // True while chip-select is asserted and the SCK timebase must run
    function automatic logic sck_active(input rdid_state_t st);
        return (st == CS_SETUP) || (st == SHIFT) || (st == CS_HOLD);
    endfunction

endpackage

// File: rtl/rdid_reader_if.sv
// rtl/rdid_reader_if.sv - request, SPI and ID-result signals of the reader (id_error with RDID_VALID_CHECK_EN)
interface rdid_reader_if;

    logic       start;
    logic       spi_miso;
    logic       spi_sck;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic [7:0] manufacture_id;
    logic [7:0] memory_type;
    logic [7:0] memory_capacity;
    logic       busy;
    logic       done;
`ifdef RDID_VALID_CHECK_EN
    logic       id_error;

    modport master (
        input  start, spi_miso,
        output spi_sck, spi_cs_n, spi_mosi,
        output manufacture_id, memory_type, memory_capacity,
        output busy, done, id_error
    );

    modport slave (
        output start, spi_miso,
        input  spi_sck, spi_cs_n, spi_mosi,
        input  manufacture_id, memory_type, memory_capacity,
        input  busy, done, id_error
    );
`else
    modport master (
        input  start, spi_miso,
        output spi_sck, spi_cs_n, spi_mosi,
        output manufacture_id, memory_type, memory_capacity,
        output busy, done
    );

    modport slave (
        output start, spi_miso,
        input  spi_sck, spi_cs_n, spi_mosi,
        input  manufacture_id, memory_type, memory_capacity,
        input  busy, done
    );
`endif

endinterface

// File: rtl/rdid_sck_gen.sv
// rtl/rdid_sck_gen.sv - SCK half-period timebase with rise/fall/phase-end strobes
module rdid_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic toggle,
    output logic sck,
    output logic sck_rise,
    output logic sck_fall,
    output logic phase_end
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign phase_end = en && (cnt == CW'(CLK_DIV - 1));
    assign sck_rise  = phase_end && toggle && !sck;
    assign sck_fall  = phase_end && toggle && sck;

    // Half-period counter; held at zero whenever the timebase is disabled
    always_ff @(posedge clk) begin
        if (!reset_n || !en) begin
            cnt <= '0;
        end else if (phase_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // SCK toggles only while shifting, so setup/hold phases keep it low
    always_ff @(posedge clk) begin
        if (!reset_n || !toggle) begin
            sck <= 1'b0;
        end else if (phase_end) begin
            sck <= ~sck;
        end
    end

endmodule

// File: rtl/rdid_reader.sv
// rtl/rdid_reader.sv - SPI-flash JEDEC ID reader top (optional id_error via RDID_VALID_CHECK_EN)
module rdid_reader
    import rdid_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    rdid_reader_if.master     bus
);

    rdid_state_t state;
    logic [4:0]  bit_cnt;
    logic [7:0]  cmd_sr;
    logic [23:0] rx_sr;
    logic        cs_n_r;
    logic        mosi_r;
    logic        busy_r;
    logic        done_r;
    logic [7:0]  mid_r;
    logic [7:0]  mtype_r;
    logic [7:0]  mcap_r;
    logic        sck;
    logic        sck_rise;
    logic        sck_fall;
    logic        phase_end;

    rdid_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (sck_active(state)),
        .toggle    (state == SHIFT),
        .sck       (sck),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .phase_end (phase_end)
    );

`ifdef RDID_VALID_CHECK_EN
    logic id_error_r;

    assign bus.id_error = id_error_r;
`endif

    // Transaction FSM with command/response shifting and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            cmd_sr  <= '0;
            rx_sr   <= '0;
            cs_n_r  <= 1'b1;
            mosi_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            mid_r   <= '0;
            mtype_r <= '0;
            mcap_r  <= '0;
`ifdef RDID_VALID_CHECK_EN
            id_error_r <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= CS_SETUP;
                        cs_n_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        bit_cnt <= '0;
                        // Bit 7 goes out during setup; the rest follows one per SCK fall
                        mosi_r  <= RDID_CMD[7];
                        cmd_sr  <= {RDID_CMD[6:0], 1'b0};
                    end
                end
                CS_SETUP: begin
                    if (phase_end) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Response bits follow the command byte; command-phase samples are dropped
                    if (sck_rise && (bit_cnt >= 5'(RDID_CMD_BITS))) begin
                        rx_sr <= {rx_sr[22:0], bus.spi_miso};
                    end
                    if (sck_fall) begin
                        if (bit_cnt == 5'(RDID_TOTAL_BITS - 1)) begin
                            state <= CS_HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            mosi_r  <= cmd_sr[7];
                            cmd_sr  <= {cmd_sr[6:0], 1'b0};
                        end
                    end
                end
                CS_HOLD: begin
                    if (phase_end) begin
                        state   <= DONE;
                        cs_n_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        mid_r   <= rx_sr[23:16];
                        mtype_r <= rx_sr[15:8];
                        mcap_r  <= rx_sr[7:0];
`ifdef RDID_VALID_CHECK_EN
                        id_error_r <= (rx_sr[23:16] == 8'h00) || (rx_sr[23:16] == 8'hFF);
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.spi_sck         = sck;
    assign bus.spi_cs_n        = cs_n_r;
    assign bus.spi_mosi        = mosi_r;
    assign bus.busy            = busy_r;
    assign bus.done            = done_r;
    assign bus.manufacture_id  = mid_r;
    assign bus.memory_type     = mtype_r;
    assign bus.memory_capacity = mcap_r;

endmodule

// File: tb/tb_rdid_reader.sv
// tb/tb_rdid_reader.sv - directed bench for rdid_reader with a mode-0 flash model
module tb_rdid_reader;

    logic clk = 1'b0;
    logic rst_n0;
    logic rst_n1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    rdid_reader_if if0 ();
    rdid_reader_if if1 ();

    rdid_reader #(.CLK_DIV(4)) dut0 (.clk(clk), .reset_n(rst_n0), .bus(if0.master));
    rdid_reader #(.CLK_DIV(2)) dut1 (.clk(clk), .reset_n(rst_n1), .bus(if1.master));

    logic       start_r [2];
    logic       force1  [2];
    logic       miso_r  [2];
    logic       sck_v   [2];
    logic       cs_v    [2];
    logic       mosi_v  [2];
    logic       busy_v  [2];
    logic       done_v  [2];
    logic [7:0] mid_v   [2];
    logic [7:0] mtype_v [2];
    logic [7:0] mcap_v  [2];

    assign if0.start = start_r[0];
    assign if1.start = start_r[1];
    assign if0.spi_miso = miso_r[0];
    assign if1.spi_miso = miso_r[1];
    assign sck_v[0] = if0.spi_sck;     assign sck_v[1] = if1.spi_sck;
    assign cs_v[0] = if0.spi_cs_n;     assign cs_v[1] = if1.spi_cs_n;
    assign mosi_v[0] = if0.spi_mosi;   assign mosi_v[1] = if1.spi_mosi;
    assign busy_v[0] = if0.busy;       assign busy_v[1] = if1.busy;
    assign done_v[0] = if0.done;       assign done_v[1] = if1.done;
    assign mid_v[0] = if0.manufacture_id;    assign mid_v[1] = if1.manufacture_id;
    assign mtype_v[0] = if0.memory_type;     assign mtype_v[1] = if1.memory_type;
    assign mcap_v[0] = if0.memory_capacity;  assign mcap_v[1] = if1.memory_capacity;

    // Flash model state, one slot per DUT
    int         cnt_m  [2];
    int         rises  [2];
    int         run    [2];
    int         hi_bad [2];
    int         lo_bad [2];
    logic [7:0] cmd_m  [2];
    logic       prev   [2];
    logic [23:0] resp = 24'h20BA18;

    function automatic int div_of(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    // Mode-0 flash: latch MOSI on SCK rise, drive next MISO bit after SCK fall
    initial begin
        for (int k = 0; k < 2; k++) begin
            cnt_m[k] = 0; rises[k] = 0; run[k] = 0; hi_bad[k] = 0; lo_bad[k] = 0;
            cmd_m[k] = 8'h00; prev[k] = 1'b0; miso_r[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (cs_v[k] !== 1'b0) begin
                    cnt_m[k] = 0;
                    miso_r[k] = force1[k];
                    run[k] = run[k] + 1;
                end else if (sck_v[k] && !prev[k]) begin
                    if (cnt_m[k] > 0 && run[k] != div_of(k)) lo_bad[k] = lo_bad[k] + 1;
                    if (cnt_m[k] == 0) cmd_m[k] = 8'h00;
                    if (cnt_m[k] < 8) cmd_m[k] = {cmd_m[k][6:0], mosi_v[k]};
                    cnt_m[k] = cnt_m[k] + 1;
                    rises[k] = rises[k] + 1;
                    run[k] = 1;
                end else if (!sck_v[k] && prev[k]) begin
                    if (run[k] != div_of(k)) hi_bad[k] = hi_bad[k] + 1;
                    run[k] = 1;
                    if (force1[k]) miso_r[k] = 1'b1;
                    else if (cnt_m[k] >= 8 && cnt_m[k] < 32) miso_r[k] = resp[31 - cnt_m[k]];
                    else miso_r[k] = 1'b0;
                end else begin
                    run[k] = run[k] + 1;
                end
                prev[k] = sck_v[k];
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One full transaction on DUT k; inject=1 adds ignored starts at cycle 100 and in DONE
    task automatic run_txn(input int k, input int inject, input logic [23:0] exp_id, input int exp_err);
        int s, e, got, gap, extra, cs_low, r0, h0, l0;
        r0 = rises[k]; h0 = hi_bad[k]; l0 = lo_bad[k];
        got = 0; gap = 0; extra = 0; cs_low = 0; e = 0;
        @(negedge clk);
        start_r[k] = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        start_r[k] = 1'b0;
        @(negedge clk);
        chk_eq("cycle1_cs_n", 32'(cs_v[k]), 32'd0);
        chk_eq("cycle1_busy", 32'(busy_v[k]), 32'd1);
        while (!got && cyc < s + 3000) begin
            @(negedge clk);
            start_r[k] = 1'b0;
            if (done_v[k]) begin
                got = 1;
                e = cyc;
                if (inject != 0) start_r[k] = 1'b1;
                chk_eq("done_busy", 32'(busy_v[k]), 32'd0);
                chk_eq("done_cs_n", 32'(cs_v[k]), 32'd1);
            end else begin
                if (!busy_v[k]) gap = gap + 1;
                if (inject != 0 && cyc == s + 99) start_r[k] = 1'b1;
            end
        end
        chk_eq("done_seen", 32'(got), 32'd1);
        chk_eq("done_latency", 32'(e - s), 32'(66 * div_of(k)));
        chk_eq("busy_gap", 32'(gap), 32'd0);
        chk_eq("manufacture_id", 32'(mid_v[k]), 32'(exp_id[23:16]));
        chk_eq("memory_type", 32'(mtype_v[k]), 32'(exp_id[15:8]));
        chk_eq("memory_capacity", 32'(mcap_v[k]), 32'(exp_id[7:0]));
`ifdef RDID_VALID_CHECK_EN
        if (k == 0) chk_eq("id_error", 32'(if0.id_error), 32'(exp_err));
        else        chk_eq("id_error", 32'(if1.id_error), 32'(exp_err));
`else
        if (exp_err < 0) $display("unexpected error tag");
`endif
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start_r[k] = 1'b0;
            if (done_v[k]) extra = extra + 1;
            if (!cs_v[k]) cs_low = cs_low + 1;
        end
        chk_eq("extra_done", 32'(extra), 32'd0);
        chk_eq("extra_cs_low", 32'(cs_low), 32'd0);
        chk_eq("sck_rises", 32'(rises[k] - r0), 32'd32);
        chk_eq("cmd_decoded", 32'(cmd_m[k]), 32'h9F);
        chk_eq("sck_high_len", 32'(hi_bad[k] - h0), 32'd0);
        chk_eq("sck_low_len", 32'(lo_bad[k] - l0), 32'd0);
    endtask

    initial begin
        int s, dn, cs_low;
        start_r[0] = 1'b0; start_r[1] = 1'b0;
        force1[0] = 1'b0;  force1[1] = 1'b0;
        rst_n0 = 1'b0;     rst_n1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_cs_n", 32'(cs_v[0]), 32'd1);
        chk_eq("rst_sck", 32'(sck_v[0]), 32'd0);
        chk_eq("rst_mosi", 32'(mosi_v[0]), 32'd0);
        chk_eq("rst_ids", {8'd0, mid_v[0], mtype_v[0], mcap_v[0]}, 32'd0);
        chk_eq("rst_busy", 32'(busy_v[0]), 32'd0);
        chk_eq("rst_done", 32'(done_v[0]), 32'd0);
        chk_eq("rst_cs_n_div2", 32'(cs_v[1]), 32'd1);
`ifdef RDID_VALID_CHECK_EN
        chk_eq("rst_id_error", 32'(if0.id_error), 32'd0);
`endif
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(0, 0, 24'h20BA18, 0);
        run_txn(0, 1, 24'h20BA18, 0);

        // Reset in the middle of a transaction
        @(negedge clk);
        start_r[0] = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        start_r[0] = 1'b0;
        while (cyc < s + 149) @(negedge clk);
        rst_n0 = 1'b0;
        @(negedge clk);
        chk_eq("midrst_cs_n", 32'(cs_v[0]), 32'd1);
        chk_eq("midrst_sck", 32'(sck_v[0]), 32'd0);
        chk_eq("midrst_ids", {8'd0, mid_v[0], mtype_v[0], mcap_v[0]}, 32'd0);
        chk_eq("midrst_busy", 32'(busy_v[0]), 32'd0);
        rst_n0 = 1'b1;
        dn = 0; cs_low = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_v[0]) dn = dn + 1;
            if (!cs_v[0]) cs_low = cs_low + 1;
        end
        chk_eq("midrst_no_done", 32'(dn), 32'd0);
        chk_eq("midrst_cs_idle", 32'(cs_low), 32'd0);
        run_txn(0, 0, 24'h20BA18, 0);

        // MISO stuck high
        force1[0] = 1'b1;
        run_txn(0, 0, 24'hFFFFFF, 1);
        force1[0] = 1'b0;

        // CLK_DIV = 2 instance
        run_txn(1, 0, 24'h20BA18, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rdid_reader.md
# rdid_reader

SPI-flash JEDEC ID reader for the RDID design. On a `start` pulse it drops chip-select, shifts out the Read-Identification command (0x9F) in SPI mode 0 and captures the three response bytes. The bytes are held in registers as `manufacture_id`, `memory_type` and `memory_capacity`. It sits directly upstream of the LED select mux, which presents one of those bytes on the board LEDs.

## Interface
Parameters:
- `CLK_DIV`, default 4: number of `clk` cycles per SCK half-period; legal range ≥ 2.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  synchronous active-low reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `spi_miso`  in  1  flash serial data out.
- `spi_sck`  out  1  SPI clock, mode 0, idles low.
- `spi_cs_n`  out  1  flash chip-select, active low.
- `spi_mosi`  out  1  flash serial data in.
- `manufacture_id`  out  8  first response byte.
- `memory_type`  out  8  second response byte.
- `memory_capacity`  out  8  third response byte.
- `busy`  out  1  high while a transaction is in flight.
- `done`  out  1  one-cycle pulse when the ID registers are updated.
- `id_error`  out  1  present only with `RDID_VALID_CHECK_EN`.

## Operation
- Reset values (while `reset_n`=0 at an edge): `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, all three ID bytes 0x00, `busy`=0, `done`=0, `id_error`=0.
- FSM states: IDLE → CS_SETUP → SHIFT → CS_HOLD → DONE → IDLE.
- IDLE:
  - `start`=1 moves to CS_SETUP.
  - `start` in any other state, including DONE, is ignored. No queuing.
- CS_SETUP: `spi_cs_n`=0, SCK low, for `CLK_DIV` cycles. `spi_mosi` presents bit 7 of 0x9F.
- SHIFT: 32 bits, indices 0..31. Each bit is `CLK_DIV` cycles SCK low, then `CLK_DIV` cycles SCK high.
  - `spi_mosi` changes only at the start of a low phase and is MSB first.
  - Bits 0–7 carry 0x9F. Bits 8–31 drive `spi_mosi`=0.
  - MISO is sampled on the `clk` edge at which SCK goes high.
  - Samples for bits 0–7 are discarded. Bits 8–31 shift MSB-first into a 24-bit register.
  - The bit counter is 5 bits wide; the exit condition is bit 31 high phase complete. It does not wrap.
- CS_HOLD: SCK low, `spi_cs_n` still 0, for `CLK_DIV` cycles.
- DONE: lasts one cycle.
  - Outputs: `spi_cs_n`=1, `busy`=0, `done`=1.
  - The shift register loads the ID bytes: [23:16]→`manufacture_id`, [15:8]→`memory_type`, [7:0]→`memory_capacity`.
- ID registers hold their last value until the next DONE or reset. Partial results are never visible on the outputs.
- Reset mid-transaction: the next edge forces the reset values and returns to IDLE. No `done` is produced.

## Timing
- Call the edge that samples `start`=1 in IDLE cycle 0.
- From cycle 1: `spi_cs_n`=0 and `busy`=1.
- First SCK rise: cycle 1+2·`CLK_DIV`.
- 32 SCK rising edges per transaction.
- `done`=1 in cycle 1+66·`CLK_DIV`. This is cycle 265 for `CLK_DIV`=4 and cycle 133 for `CLK_DIV`=2.
- `busy` is high from cycle 1 to cycle 66·`CLK_DIV`, and low in the DONE cycle.
- Back-to-back: the earliest next accepted `start` is the cycle after DONE.
- CS high time between transactions: at least 1 cycle, plus any IDLE time.

## Configuration
- `RDID_VALID_CHECK_EN` defined:
  - The `id_error` port exists and is registered. It is loaded in the DONE cycle alongside the ID bytes.
  - It is set to 1 if the captured `manufacture_id` is 0x00 or 0xFF; otherwise 0.
  - The ID bytes are loaded regardless.
- Not defined: the `id_error` port and its logic are absent. All other behaviour is identical.

## Structure
- Package `rdid_pkg`:
  - `RDID_CMD` = 8'h9F.
  - `RDID_CMD_BITS` = 8.
  - `RDID_TOTAL_BITS` = 32.
  - State enum `rdid_state_t` {IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE}.
- Sub-module `rdid_sck_gen`: half-period counter with `CLK_DIV`.
  - Outputs: `sck_rise`/`sck_fall` strobes and a `phase_end` strobe used by CS_SETUP/CS_HOLD.
  - Enabled by the FSM.
- Top level `rdid_reader`: FSM, bit counter, command/response shift registers, output registers.

## Test plan
The bench uses a behavioural mode-0 flash model returning 0x20, 0xBA, 0x18.
- Reset held for 3 cycles → `spi_cs_n`=1, `spi_sck`=0, ID bytes 0x00, `busy`=0, `done`=0.
- `start` pulse, `CLK_DIV`=4 → model decodes 0x9F; `done` in cycle 265; outputs 0x20/0xBA/0x18; exactly 32 SCK rises; `id_error`=0.
- Second `start` at cycle 100 and another in the DONE cycle → both ignored; one transaction, 32 SCK rises.
- `reset_n`=0 at cycle 150 → `spi_cs_n`=1 on the next edge, ID bytes 0x00, no `done`. A fresh `start` then completes normally with 0x20/0xBA/0x18.
- MISO held at 1 with `RDID_VALID_CHECK_EN` → all bytes 0xFF, `id_error`=1. Without the macro the bytes are 0xFF and there is no `id_error` port.
- `CLK_DIV`=2 → `done` in cycle 133, SCK high and low each 2 cycles, same captured bytes.
